// File: rtl/dvi_tmds_encoder.sv
// dvi_tmds_encoder: three-channel DVI TMDS 8b/10b encoder with DC balance.
// Two-stage pipeline: transition minimisation, then DC balance / control tokens.
// Build option: define TMDS_HSYNC_POS_EN to invert hsync before it becomes C0.
module dvi_tmds_encoder (
  input  logic       pclk,
  input  logic       rst,
  input  logic       vde,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [2:0] RGB,
  output logic [9:0] tmds0,
  output logic [9:0] tmds1,
  output logic [9:0] tmds2
);

  localparam int unsigned NumCh = 3;
  localparam int unsigned ByteW = 8;
  localparam int unsigned QmW   = ByteW + 1;
  localparam int unsigned SymW  = 10;
  localparam int unsigned CntW  = 5;
  localparam int unsigned PopW  = 4;
  localparam int unsigned BalW  = SymW + CntW;

  localparam logic [SymW-1:0] TokC00 = 10'b1101010100;
  localparam logic [SymW-1:0] TokC01 = 10'b0010101011;
  localparam logic [SymW-1:0] TokC10 = 10'b0101010100;
  localparam logic [SymW-1:0] TokC11 = 10'b1010101011;

  function automatic logic [PopW-1:0] popcount8(input logic [ByteW-1:0] d);
    logic [PopW-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < ByteW; i++) n = n + PopW'(d[i]);
    return n;
  endfunction

  function automatic logic [QmW-1:0] tm_encode(input logic [ByteW-1:0] d);
    logic [PopW-1:0] n1d;
    logic            use_xnor;
    logic [QmW-1:0]  qm;
    n1d      = popcount8(d);
    use_xnor = (n1d > PopW'(4)) || ((n1d == PopW'(4)) && !d[0]);
    qm       = '0;
    qm[0]    = d[0];
    for (int unsigned i = 1; i < ByteW; i++)
      qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[ByteW] = ~use_xnor;
    return qm;
  endfunction

  function automatic logic [SymW-1:0] ctrl_token(input logic [1:0] c);
    logic [SymW-1:0] tok;
    case (c)
      2'b00:   tok = TokC00;
      2'b01:   tok = TokC01;
      2'b10:   tok = TokC10;
      default: tok = TokC11;
    endcase
    return tok;
  endfunction

  // Returns {symbol, next running disparity} for one data symbol.
  function automatic logic [BalW-1:0] dc_balance(input logic [QmW-1:0]         qm,
                                                 input logic signed [CntW-1:0] cnt);
    logic [PopW-1:0]        n1;
    logic [PopW-1:0]        n0;
    logic signed [CntW-1:0] diff;
    logic signed [CntW-1:0] bias_b;
    logic signed [CntW-1:0] bias_c;
    logic signed [CntW-1:0] cnt_nxt;
    logic [SymW-1:0]        sym;
    n1     = popcount8(qm[ByteW-1:0]);
    n0     = PopW'(ByteW) - n1;
    diff   = $signed(CntW'(n1)) - $signed(CntW'(n0));
    bias_b = qm[ByteW] ? $signed(CntW'(2)) : $signed(CntW'(0));
    bias_c = qm[ByteW] ? $signed(CntW'(0)) : $signed(CntW'(2));
    if ((cnt == '0) || (n1 == n0)) begin
      sym     = {~qm[ByteW], qm[ByteW], qm[ByteW] ? qm[ByteW-1:0] : ~qm[ByteW-1:0]};
      cnt_nxt = qm[ByteW] ? (cnt + diff) : (cnt - diff);
    end else if ((!cnt[CntW-1] && (n1 > n0)) || (cnt[CntW-1] && (n0 > n1))) begin
      sym     = {1'b1, qm[ByteW], ~qm[ByteW-1:0]};
      cnt_nxt = cnt + bias_b - diff;
    end else begin
      sym     = {1'b0, qm[ByteW], qm[ByteW-1:0]};
      cnt_nxt = cnt - bias_c + diff;
    end
    return {sym, cnt_nxt};
  endfunction

  logic c0_in;
`ifdef TMDS_HSYNC_POS_EN
  assign c0_in = ~hsync;
`else
  assign c0_in = hsync;
`endif

  logic                   de_q;
  logic [1:0]             ctl_q;
  logic [QmW-1:0]         qm_d  [NumCh];
  logic [QmW-1:0]         qm_q  [NumCh];
  logic signed [CntW-1:0] cnt_d [NumCh];
  logic signed [CntW-1:0] cnt_q [NumCh];
  logic [SymW-1:0]        sym_d [NumCh];
  logic [SymW-1:0]        sym_q [NumCh];
  logic [BalW-1:0]        bal;

  // Stage 1 combinational: expand each colour bit to a byte and minimise transitions.
  always_comb begin
    for (int unsigned ch = 0; ch < NumCh; ch++) qm_d[ch] = tm_encode({ByteW{RGB[ch]}});
  end

  // Stage 1 register: q_m per channel plus de and channel-0 control bits {vsync, C0}.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      de_q  <= 1'b0;
      ctl_q <= 2'b00;
      for (int unsigned ch = 0; ch < NumCh; ch++) qm_q[ch] <= '0;
    end else begin
      de_q  <= vde;
      ctl_q <= {vsync, c0_in};
      for (int unsigned ch = 0; ch < NumCh; ch++) qm_q[ch] <= qm_d[ch];
    end
  end

  // Stage 2 combinational: DC-balanced data symbol or control token; disparity clears in blanking.
  always_comb begin
    bal = '0;
    for (int unsigned ch = 0; ch < NumCh; ch++) begin
      sym_d[ch] = TokC00;
      cnt_d[ch] = '0;
      if (de_q) begin
        bal       = dc_balance(qm_q[ch], cnt_q[ch]);
        sym_d[ch] = bal[BalW-1:CntW];
        cnt_d[ch] = $signed(bal[CntW-1:0]);
      end
    end
    if (!de_q) sym_d[0] = ctrl_token(ctl_q);
  end

  // Stage 2 register: running disparity and output symbols.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      for (int unsigned ch = 0; ch < NumCh; ch++) begin
        cnt_q[ch] <= '0;
        sym_q[ch] <= TokC00;
      end
    end else begin
      for (int unsigned ch = 0; ch < NumCh; ch++) begin
        cnt_q[ch] <= cnt_d[ch];
        sym_q[ch] <= sym_d[ch];
      end
    end
  end

  assign tmds0 = sym_q[0];
  assign tmds1 = sym_q[1];
  assign tmds2 = sym_q[2];

endmodule
